// File: rtl/bip_report_pkg.sv
// Shared types and constants for the BIP halt-report block.
package bip_report_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SEND   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int          FRAME_LEN          = 8;
    localparam int          IDX_W              = $clog2(FRAME_LEN);
    localparam logic [7:0]  HEADER_DEFAULT     = 8'hA5;
    localparam logic [4:0]  HLT_OPCODE_DEFAULT = 5'b00000;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bip_report_if.sv
// Byte-stream handshake towards the UART transmitter.
interface bip_report_if;

    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);

endinterface

// File: rtl/bip_report_frame_mux.sv
// Selects one byte of the report frame from the latched snapshot;
// the final byte is the XOR checksum of the seven before it.
module report_frame_mux
    import bip_report_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic [10:0]      snap_pc,
    input  logic [15:0]      snap_acc,
    input  logic [15:0]      snap_cyc,
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       frame_byte
);

    logic [7:0] chk;

    // Checksum over header and payload bytes.
    always_comb begin
        chk = HEADER ^ {5'b0, snap_pc[10:8]} ^ snap_pc[7:0]
            ^ snap_acc[15:8] ^ snap_acc[7:0]
            ^ snap_cyc[15:8] ^ snap_cyc[7:0];
    end

    // Byte select by frame position.
    always_comb begin
        case (idx)
            3'd0:    frame_byte = HEADER;
            3'd1:    frame_byte = {5'b0, snap_pc[10:8]};
            3'd2:    frame_byte = snap_pc[7:0];
            3'd3:    frame_byte = snap_acc[15:8];
            3'd4:    frame_byte = snap_acc[7:0];
            3'd5:    frame_byte = snap_cyc[15:8];
            3'd6:    frame_byte = snap_cyc[7:0];
            default: frame_byte = chk;
        endcase
    end

endmodule

// File: rtl/bip_report.sv
// Watches the CPU for the halt opcode, stalls it, and streams an 8-byte
// report (PC, ACC, cycle count, checksum) to a UART, then waits for START.
module bip_report
    import bip_report_pkg::*;
#(
    parameter logic [4:0] HLT_OPCODE = HLT_OPCODE_DEFAULT,
    parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [15:0]  INSTRUCTION,
    input  logic [10:0]  PC,
    input  logic [15:0]  ACC,
    input  logic         START,
    output logic         CPU_EN,
    output logic         DONE,
    bip_report_if.master tx
);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      cyc_cnt;
    logic [IDX_W-1:0] idx;
    logic [10:0]      snap_pc;
    logic [15:0]      snap_acc;
    logic [15:0]      snap_cyc;
    logic [7:0]       frame_byte;
    logic             is_hlt;
    logic             tx_fire;
    logic             last_byte;
    logic             unused_operand;

    // Only the opcode field matters here; the operand bits are ignored.
    assign unused_operand = ^INSTRUCTION[10:0];

    assign is_hlt    = (INSTRUCTION[15:11] == HLT_OPCODE);
    assign tx_fire   = (state == SEND) && tx.TX_READY;
    assign last_byte = (idx == IDX_W'(FRAME_LEN - 1));

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= RUN;
        else        state <= state_nxt;
    end

    // Next-state: halt starts a frame, the last accepted byte halts, START re-arms.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (is_hlt)               state_nxt = SEND;
            SEND:    if (tx_fire && last_byte) state_nxt = HALTED;
            HALTED:  if (START)                state_nxt = RUN;
            default:                           state_nxt = RUN;
        endcase
    end

    // Cycle counter, byte index and halt-time snapshot.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cyc_cnt  <= '0;
            idx      <= '0;
            snap_pc  <= '0;
            snap_acc <= '0;
            snap_cyc <= '0;
        end else begin
            case (state)
                RUN: begin
                    cyc_cnt <= sat_inc(cyc_cnt);
                    if (is_hlt) begin
                        snap_pc  <= PC;
                        snap_acc <= ACC;
                        snap_cyc <= sat_inc(cyc_cnt);
                        idx      <= '0;
                    end
                end
                SEND:    if (tx.TX_READY) idx <= idx + IDX_W'(1);
                HALTED:  if (START) cyc_cnt <= '0;
                default: ;
            endcase
        end
    end

    report_frame_mux #(
        .HEADER (HEADER)
    ) u_frame_mux (
        .snap_pc    (snap_pc),
        .snap_acc   (snap_acc),
        .snap_cyc   (snap_cyc),
        .idx        (idx),
        .frame_byte (frame_byte)
    );

    // Outputs decoded from state; the frame byte is only exposed while sending.
    always_comb begin
        CPU_EN      = 1'b1;
        DONE        = 1'b0;
        tx.TX_VALID = 1'b0;
        tx.TX_DATA  = 8'h00;
        case (state)
            SEND: begin
                CPU_EN      = 1'b0;
                tx.TX_VALID = 1'b1;
                tx.TX_DATA  = frame_byte;
            end
            HALTED: begin
                CPU_EN = 1'b0;
                DONE   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bip_report.sv
// Randomized self-checking bench for bip_report with a frame-level model.
module tb_bip_report;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] INSTRUCTION;
    logic [10:0] PC;
    logic [15:0] ACC;
    logic        START;
    logic        CPU_EN;
    logic        DONE;
    int          total = 0;
    int          bad   = 0;

    bip_report_if tx_if ();

    bip_report dut (
        .CLK         (clk),
        .RESET       (rst_n),
        .INSTRUCTION (INSTRUCTION),
        .PC          (PC),
        .ACC         (ACC),
        .START       (START),
        .CPU_EN      (CPU_EN),
        .DONE        (DONE),
        .tx          (tx_if)
    );

    always #5 clk = ~clk;

    // Reference frame: header, PC, ACC, cycle count, XOR of the first seven.
    function automatic logic [7:0] exp_byte(input logic [10:0] pc, input logic [15:0] acc,
                                            input logic [15:0] cyc, input int i);
        logic [7:0] b [8];
        b[0] = 8'hA5;
        b[1] = {5'b0, pc[10:8]};
        b[2] = pc[7:0];
        b[3] = acc[15:8];
        b[4] = acc[7:0];
        b[5] = cyc[15:8];
        b[6] = cyc[7:0];
        b[7] = 8'h00;
        for (int j = 0; j < 7; j++) b[7] = b[7] ^ b[j];
        return b[i];
    endfunction

    function automatic logic [15:0] exp_cyc(input int n_run);
        return (n_run + 1 > 65535) ? 16'hFFFF : 16'(n_run + 1);
    endfunction

    function automatic logic [15:0] non_hlt();
        return {5'($urandom_range(1, 31)), 11'($urandom)};
    endfunction

    // n RUN cycles of ordinary instructions (random START/TX_READY that must be ignored), then HLT.
    task automatic run_program(input int n, input logic [10:0] pc, input logic [15:0] acc);
        for (int i = 0; i < n; i++) begin
            INSTRUCTION    = non_hlt();
            PC             = 11'($urandom);
            ACC            = 16'($urandom);
            START          = 1'($urandom_range(0, 1));
            tx_if.TX_READY = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        INSTRUCTION    = {5'b00000, 11'($urandom)};
        PC             = pc;
        ACC            = acc;
        START          = 1'b0;
        tx_if.TX_READY = 1'($urandom_range(0, 1));
        @(negedge clk);
        INSTRUCTION    = non_hlt();
        tx_if.TX_READY = 1'b0;
    endtask

    // mode 0: always ready; 1: stall 3 cycles on byte 2; 2: random ready; 3: random ready + START pulses
    task automatic collect_frame(input logic [10:0] pc, input logic [15:0] acc, input logic [15:0] cyc,
                                 input int mode, input int nbytes);
        int         k = 0;
        int         iter = 0;
        int         stalls = 0;
        logic       rdy;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] want;
        while (k < nbytes && iter < 200) begin
            total++;
            if (tx_if.TX_VALID !== 1'b1 || CPU_EN !== 1'b0) begin
                bad++;
                $display("FAIL send_status k=%0d got valid=%b cpu_en=%b expected valid=1 cpu_en=0",
                         k, tx_if.TX_VALID, CPU_EN);
            end
            if (prev_stall) begin
                total++;
                if (tx_if.TX_DATA !== prev_data) begin
                    bad++;
                    $display("FAIL hold_stable k=%0d got %h expected %h", k, tx_if.TX_DATA, prev_data);
                end
            end
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    rdy = !(k == 2 && stalls < 3);
                    if (!rdy) stalls++;
                end
                3: begin
                    rdy   = 1'($urandom_range(0, 1));
                    START = 1'($urandom_range(0, 1));
                end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            PC             = 11'($urandom);
            ACC            = 16'($urandom);
            tx_if.TX_READY = rdy;
            if (rdy) begin
                want = exp_byte(pc, acc, cyc, k);
                total++;
                if (tx_if.TX_DATA !== want) begin
                    bad++;
                    $display("FAIL byte%0d got %h expected %h", k, tx_if.TX_DATA, want);
                end
                k++;
            end
            prev_stall = !rdy;
            prev_data  = tx_if.TX_DATA;
            iter++;
            @(negedge clk);
        end
        START          = 1'b0;
        tx_if.TX_READY = 1'b0;
        if (k < nbytes) begin
            total++;
            bad++;
            $display("FAIL frame_timeout got %0d bytes expected %0d", k, nbytes);
        end
        if (nbytes == 8) begin
            total++;
            if (tx_if.TX_VALID !== 1'b0 || DONE !== 1'b1 || CPU_EN !== 1'b0) begin
                bad++;
                $display("FAIL halted_state got valid=%b done=%b cpu_en=%b expected 0 1 0",
                         tx_if.TX_VALID, DONE, CPU_EN);
            end
        end
    endtask

    task automatic do_start();
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        INSTRUCTION    = 16'hFFFF;
        PC             = '0;
        ACC            = '0;
        START          = 1'b0;
        tx_if.TX_READY = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (tx_if.TX_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got %b expected 0", tx_if.TX_VALID); end
        total++;
        if (tx_if.TX_DATA !== 8'h00) begin bad++; $display("FAIL rst_data got %h expected 00", tx_if.TX_DATA); end
        total++;
        if (DONE !== 1'b0) begin bad++; $display("FAIL rst_done got %b expected 0", DONE); end
        total++;
        if (CPU_EN !== 1'b1) begin bad++; $display("FAIL rst_cpu_en got %b expected 1", CPU_EN); end
        rst_n          = 1'b1;
        tx_if.TX_READY = 1'b0;
    endtask

    task automatic test_basic();
        run_program(5, 11'd5, 16'h1234);
        collect_frame(11'd5, 16'h1234, exp_cyc(5), 0, 8);
    endtask

    task automatic test_stall();
        do_start();
        run_program(5, 11'd5, 16'h1234);
        collect_frame(11'd5, 16'h1234, exp_cyc(5), 1, 8);
    endtask

    task automatic test_random();
        int          n;
        logic [10:0] pc;
        logic [15:0] acc;
        for (int t = 0; t < 5; t++) begin
            do_start();
            n   = int'($urandom_range(0, 40));
            pc  = 11'($urandom);
            acc = 16'($urandom);
            run_program(n, pc, acc);
            collect_frame(pc, acc, exp_cyc(n), 2, 8);
        end
    endtask

    task automatic test_saturate();
        do_start();
        run_program(70000, 11'h7FF, 16'hBEEF);
        collect_frame(11'h7FF, 16'hBEEF, exp_cyc(70000), 0, 8);
    endtask

    task automatic test_start();
        logic [10:0] pc;
        logic [15:0] acc;
        for (int i = 0; i < 3; i++) begin
            tx_if.TX_READY = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            if (DONE !== 1'b1 || CPU_EN !== 1'b0 || tx_if.TX_VALID !== 1'b0) begin
                bad++;
                $display("FAIL halted_hold got done=%b cpu_en=%b valid=%b expected 1 0 0",
                         DONE, CPU_EN, tx_if.TX_VALID);
            end
        end
        tx_if.TX_READY = 1'b0;
        do_start();
        total++;
        if (DONE !== 1'b0 || CPU_EN !== 1'b1) begin
            bad++;
            $display("FAIL start_rearm got done=%b cpu_en=%b expected 0 1", DONE, CPU_EN);
        end
        pc  = 11'($urandom);
        acc = 16'($urandom);
        run_program(3, pc, acc);
        collect_frame(pc, acc, exp_cyc(3), 3, 8);
        do_start();
        pc  = 11'($urandom);
        acc = 16'($urandom);
        run_program(0, pc, acc);
        collect_frame(pc, acc, exp_cyc(0), 0, 8);
    endtask

    task automatic test_reset_mid();
        logic [10:0] pc;
        logic [15:0] acc;
        do_start();
        run_program(7, 11'h123, 16'h5A5A);
        collect_frame(11'h123, 16'h5A5A, exp_cyc(7), 0, 4);
        tx_if.TX_READY = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (tx_if.TX_VALID !== 1'b0 || tx_if.TX_DATA !== 8'h00) begin
            bad++;
            $display("FAIL midrst_tx got valid=%b data=%h expected 0 00", tx_if.TX_VALID, tx_if.TX_DATA);
        end
        total++;
        if (CPU_EN !== 1'b1 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL midrst_ctrl got cpu_en=%b done=%b expected 1 0", CPU_EN, DONE);
        end
        @(negedge clk);
        rst_n          = 1'b1;
        tx_if.TX_READY = 1'b0;
        pc  = 11'($urandom);
        acc = 16'($urandom);
        run_program(2, pc, acc);
        collect_frame(pc, acc, exp_cyc(2), 2, 8);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_saturate();
        test_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
